// File: rtl/traffic_phase_monitor.sv
// Traffic phase monitor: decodes the observed lamp outputs of a traffic light
// controller into a phase and flags illegal lamp codes, illegal phase
// sequences and, when TPM_DURATION_CHECK_EN is defined, min/max hold
// violations. All outputs are registered one cycle after the lamp sample.
module traffic_phase_monitor #(
  parameter logic [15:0] RED_MIN    = 16'd100,
  parameter logic [15:0] GREEN_MIN  = 16'd80,
  parameter logic [15:0] YELLOW_MIN = 16'd20,
  parameter logic [15:0] PED_MIN    = 16'd40,
  parameter logic [15:0] EMG_MIN    = 16'd60,
  parameter logic [15:0] PHASE_MAX  = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  traffic,
  input  logic        pedestrian_light,
  input  logic        emergency_light,
  input  logic        clear_err,
  output logic [2:0]  phase,
  output logic        phase_valid,
  output logic        phase_change,
  output logic [15:0] last_duration,
  output logic        err_code,
  output logic        err_seq,
  output logic        err_duration,
  output logic [7:0]  green_count
);

  typedef enum logic [2:0] {
    PhRed     = 3'd0,
    PhGreen   = 3'd1,
    PhYellow  = 3'd2,
    PhPed     = 3'd3,
    PhEmg     = 3'd4,
    PhIllegal = 3'd7
  } phase_e;

  // phase_q is the single input register: the lamp sample is held in its
  // decoded form, so outputs carry exactly one cycle of latency.
  phase_e      sample_ph;
  phase_e      phase_q;
  logic [15:0] count_q;
  logic        is_change;
  logic        trans_legal;
  logic        code_err;
  logic        seq_err;
  logic        dur_err;

  assign phase = phase_q;

  // Decode the raw lamp combination into a phase.
  always_comb begin
    sample_ph = PhIllegal;
    case ({traffic, pedestrian_light, emergency_light})
      5'b100_0_0: sample_ph = PhRed;
      5'b001_0_0: sample_ph = PhGreen;
      5'b010_0_0: sample_ph = PhYellow;
      5'b100_1_0: sample_ph = PhPed;
      5'b100_0_1: sample_ph = PhEmg;
      default:    sample_ph = PhIllegal;
    endcase
  end

  // Judge the transition from the previously registered phase to the new sample.
  always_comb begin
    trans_legal = 1'b0;
    if (sample_ph == phase_q) begin
      trans_legal = 1'b1;
    end else if (sample_ph == PhEmg) begin
      trans_legal = (phase_q != PhIllegal);
    end else begin
      case (phase_q)
        PhRed:    trans_legal = (sample_ph == PhGreen) || (sample_ph == PhPed);
        PhGreen:  trans_legal = (sample_ph == PhYellow) || (sample_ph == PhPed);
        PhYellow: trans_legal = (sample_ph == PhRed);
        PhPed:    trans_legal = (sample_ph == PhRed);
        PhEmg:    trans_legal = (sample_ph == PhRed);
        default:  trans_legal = 1'b0;
      endcase
    end
  end

  // The very first sample after reset has no predecessor, so it is never a change.
  assign is_change = phase_valid && (sample_ph != phase_q);
  assign code_err  = (sample_ph == PhIllegal);
  assign seq_err   = is_change && !trans_legal;

`ifdef TPM_DURATION_CHECK_EN
  logic [15:0] min_hold;
  logic        min_exempt;

  // Minimum hold on exit (emergency preemption and GREEN->PED are exempt),
  // maximum hold flagged on the cycle the counter reaches PHASE_MAX.
  always_comb begin
    case (phase_q)
      PhRed:    min_hold = RED_MIN;
      PhGreen:  min_hold = GREEN_MIN;
      PhYellow: min_hold = YELLOW_MIN;
      PhPed:    min_hold = PED_MIN;
      PhEmg:    min_hold = EMG_MIN;
      default:  min_hold = 16'd0;
    endcase
    min_exempt = (sample_ph == PhEmg) || ((phase_q == PhGreen) && (sample_ph == PhPed));
    dur_err    = 1'b0;
    if (is_change) begin
      dur_err = !min_exempt && (count_q < min_hold);
    end else if (phase_valid && (count_q != 16'hFFFF)) begin
      dur_err = ((count_q + 16'd1) == PHASE_MAX);
    end
  end
`else
  // Hold-time checking is compiled out; the limits stay on the interface only.
  logic [15:0] unused_limits;
  assign unused_limits = RED_MIN ^ GREEN_MIN ^ YELLOW_MIN ^ PED_MIN ^ EMG_MIN ^ PHASE_MAX;
  assign dur_err       = 1'b0;
  assign err_duration  = 1'b0;
`endif

  // Phase tracking, duration counting and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= PhRed;
      phase_valid   <= 1'b0;
      phase_change  <= 1'b0;
      last_duration <= 16'd0;
      count_q       <= 16'd0;
      green_count   <= 8'd0;
      err_code      <= 1'b0;
      err_seq       <= 1'b0;
`ifdef TPM_DURATION_CHECK_EN
      err_duration  <= 1'b0;
`endif
    end else begin
      phase_q      <= sample_ph;
      phase_valid  <= 1'b1;
      phase_change <= is_change;
      if (!phase_valid) begin
        count_q <= 16'd1;
      end else if (is_change) begin
        last_duration <= count_q;
        count_q       <= 16'd1;
        if (sample_ph == PhGreen) begin
          green_count <= green_count + 8'd1;
        end
      end else if (count_q != 16'hFFFF) begin
        count_q <= count_q + 16'd1;
      end
      // A fresh error in the clearing cycle keeps its flag set.
      err_code <= code_err | (err_code & ~clear_err);
      err_seq  <= seq_err | (err_seq & ~clear_err);
`ifdef TPM_DURATION_CHECK_EN
      err_duration <= dur_err | (err_duration & ~clear_err);
`endif
    end
  end

endmodule
